// File: rtl/external_interrupt_controller.sv
// External interrupt controller: synchronizes raw IRQ lines, latches rising edges
// as pending and hands one request at a time to the core with a toggle-ack handshake.
module external_interrupt_controller #(
  parameter int ID_WIDTH       = 1,
  parameter int REQ_LOW_CYCLES = 4
) (
  input  logic                       Sys_Clock,
  input  logic                       Sys_Reset,
  input  logic [(1<<ID_WIDTH)-1:0]   Irq_In,
  input  logic [(1<<ID_WIDTH)-1:0]   Irq_Enable,
  input  logic                       EIC_I_Ack,
  output logic                       EIC_I_Req,
  output logic [ID_WIDTH-1:0]        EIC_I_Id,
  output logic [(1<<ID_WIDTH)-1:0]   Irq_Pending,
  output logic                       Busy
);

  localparam int NUM_SRC = 1 << ID_WIDTH;
  localparam int CNT_W   = $clog2(REQ_LOW_CYCLES) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [NUM_SRC-1:0]  irq_s1_q, irq_s2_q, irq_last_q;
  logic                ack_s1_q, ack_s2_q, ack_last_q;
  logic [NUM_SRC-1:0]  pend_q, pend_d;
  logic [1:0]          state_q, state_d;
  logic                req_q, req_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_SRC-1:0]  rise, armed;
  logic                ack_evt;

  function automatic logic [ID_WIDTH-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    lowest_set = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) lowest_set = ID_WIDTH'(i);
  endfunction

  assign rise    = irq_s2_q & ~irq_last_q;
  assign ack_evt = ack_s2_q ^ ack_last_q;
  assign armed   = pend_q & Irq_Enable;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | rise;
    case (state_q)
      S_IDLE: begin
        if (|armed) begin
          id_d    = lowest_set(armed);
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A fresh edge on the served line in the clearing cycle must survive.
        if (ack_evt) begin
          req_d        = 1'b0;
          pend_d[id_q] = rise[id_q];
          cnt_d        = '0;
          state_d      = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(REQ_LOW_CYCLES - 1)) state_d = S_IDLE;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      irq_last_q <= '0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
      ack_last_q <= 1'b0;
      pend_q     <= '0;
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      id_q       <= '0;
      cnt_q      <= '0;
    end else begin
      irq_s1_q   <= Irq_In;
      irq_s2_q   <= irq_s1_q;
      irq_last_q <= irq_s2_q;
      ack_s1_q   <= EIC_I_Ack;
      ack_s2_q   <= ack_s1_q;
      ack_last_q <= ack_s2_q;
      pend_q     <= pend_d;
      state_q    <= state_d;
      req_q      <= req_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign EIC_I_Req   = req_q;
  assign EIC_I_Id    = id_q;
  assign Irq_Pending = pend_q;
  assign Busy        = (state_q != S_IDLE);

endmodule
